// File: rtl/mips_cpu_definitions.sv
// -----------------------------------------------------------------------------
// mips_cpu_definitions
//   Shared type definitions for the multi-cycle MIPS core and its load/store
//   unit.
//   - opcode_t    : primary opcode field of the MIPS instruction word
//   - state_t     : top-level state of the multi-cycle core
//   - lsu_op_t    : memory operation requested from the load/store unit
//   - lsu_state_t : internal state of the load/store unit
//   Helper functions classify lsu_op_t values as stores.
// -----------------------------------------------------------------------------
package mips_cpu_definitions;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDIU = 6'h09,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LWL   = 6'h22,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_LWR   = 6'h26,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM_ACCESS,
        WRITEBACK
    } state_t;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    function automatic logic lsu_is_store(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mips_lsu_lanes.sv
// -----------------------------------------------------------------------------
// mips_lsu_lanes
//   Purely combinational byte-lane steering for the load/store unit.
//   Ports:
//     op          in  operation (lsu_op_t)
//     offset      in  byte offset within the word (address bits [1:0])
//     wdata       in  store source data
//     rt          in  current rt value, merge source for LWL/LWR
//     rdata       in  word read from memory
//     byteenable  out Avalon byte enables for this access
//     writedata   out lane-replicated store data
//     load_result out extended or merged load value
//     misaligned  out access violates natural alignment (only when
//                     ALIGN_CHECK != 0)
//   Little-endian: byte lane i holds bits [8i+7:8i].
// -----------------------------------------------------------------------------
module mips_lsu_lanes
    import mips_cpu_definitions::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  lsu_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_result,
    output logic        misaligned
);

    // Byte shift amounts: 8*o and 8*(3-o). For a 2-bit o, 3-o == ~o.
    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [31:0] rd_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        mis_raw;

    assign sh_lo    = {offset, 3'b000};
    assign sh_hi    = {~offset, 3'b000};
    assign rd_shift = rdata >> sh_lo;
    assign byte_sel = rd_shift[7:0];
    // Halfword selection uses only offset[1], so with the alignment check
    // disabled a halfword at an odd offset silently falls back to o&2.
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byteenable  = 4'b0000;
        writedata   = 32'h0;
        load_result = 32'h0;
        mis_raw     = 1'b0;

        case (op)
            LB, LBU: begin
                byteenable  = 4'b0001 << offset;
                load_result = {{24{(op == LB) && byte_sel[7]}}, byte_sel};
            end
            LH, LHU: begin
                byteenable  = offset[1] ? 4'b1100 : 4'b0011;
                load_result = {{16{(op == LH) && half_sel[15]}}, half_sel};
                mis_raw     = offset[0];
            end
            LW: begin
                byteenable  = 4'b1111;
                load_result = rdata;
                mis_raw     = (offset != 2'b00);
            end
            LWL: begin
                // Memory bytes o..0 land in result bytes 3..3-o; the
                // untouched low bytes keep rt.
                byteenable  = 4'b1111 >> ~offset;
                load_result = (rdata << sh_hi) | (rt & ~(32'hFFFF_FFFF << sh_hi));
            end
            LWR: begin
                // Memory bytes o..3 land in result bytes 0..3-o; the
                // untouched high bytes keep rt.
                byteenable  = 4'b1111 << offset;
                load_result = (rdata >> sh_lo) | (rt & ~(32'hFFFF_FFFF >> sh_lo));
            end
            SB: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{wdata[7:0]}};
            end
            SH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
                mis_raw    = offset[0];
            end
            SW: begin
                byteenable = 4'b1111;
                writedata  = wdata;
                mis_raw    = (offset != 2'b00);
            end
            default: begin
                byteenable = 4'b0000;
            end
        endcase
    end

    assign misaligned = mis_raw && (ALIGN_CHECK != 0);

endmodule

// File: rtl/mips_lsu.sv
// -----------------------------------------------------------------------------
// mips_lsu
//   Load/store unit between the multi-cycle MIPS core and an Avalon-MM master
//   port. One load or store is accepted per request handshake, driven on the
//   bus with registered strobes, and completed with a one-cycle response.
//
//   Parameters:
//     ADDR_W      byte-address width, also the Avalon address width
//     ALIGN_CHECK 1 = misaligned LH/LHU/LW/SH/SW answered with resp_err
//                 0 = offending low address bits are ignored
//     MAX_WAIT    0 = wait forever; N>0 = abort after N stalled bus cycles
//
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     req_valid/req_ready             request handshake
//     req_op, req_addr                operation and effective byte address
//     req_wdata, req_rt               store data, LWL/LWR merge source
//     resp_valid/resp_rdata/resp_err  one-cycle completion
//     address/read/write/writedata/byteenable/readdata/waitrequest  Avalon
//
//   Request handshake: a request transfers on a rising edge where
//   req_valid && req_ready. req_ready is high only in IDLE, so it drops the
//   cycle after acceptance and returns once the response has been given.
//   Request fields need only be valid on the accepting edge. There is no
//   response back-pressure: resp_valid is a single-cycle pulse in RESP.
//
//   Avalon side: read/write are high only in BUS, never together, and
//   address/byteenable/writedata/read/write hold steady while waitrequest=1.
// -----------------------------------------------------------------------------
module mips_lsu
    import mips_cpu_definitions::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ALIGN_CHECK = 1,
    parameter int MAX_WAIT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  lsu_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    // The counter only ever needs to hold 0..MAX_WAIT-1: the abort fires on
    // the stalled cycle that would bring it to MAX_WAIT.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    lsu_state_t       state;
    lsu_state_t       state_next;

    lsu_op_t          op_q;
    logic [1:0]       off_q;
    logic [31:0]      rt_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_last;

    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    lsu_op_t          lane_op;
    logic [1:0]       lane_off;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wd;
    logic [31:0]      lane_load;
    logic             lane_mis;

    // One lane instance serves both phases: in IDLE it formats the incoming
    // request; afterwards it sees the registered op/offset so the load result
    // is built from readdata on the completing edge.
    assign lane_op  = (state == IDLE) ? req_op : op_q;
    assign lane_off = (state == IDLE) ? req_addr[1:0] : off_q;

    mips_lsu_lanes #(
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_lanes (
        .op          (lane_op),
        .offset      (lane_off),
        .wdata       (req_wdata),
        .rt          (rt_q),
        .rdata       (readdata),
        .byteenable  (lane_be),
        .writedata   (lane_wd),
        .load_result (lane_load),
        .misaligned  (lane_mis)
    );

    assign wait_last = (MAX_WAIT > 0) && (32'(wait_cnt) == 32'(MAX_WAIT - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = lane_mis ? RESP : BUS;
                end
            end
            BUS: begin
                if (!waitrequest || wait_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= LB;
            off_q        <= 2'b00;
            rt_q         <= 32'h0;
            wait_cnt     <= '0;
            address      <= '0;
            byteenable   <= 4'b0000;
            writedata    <= 32'h0;
            read         <= 1'b0;
            write        <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        off_q <= req_addr[1:0];
                        rt_q  <= req_rt;
                        if (lane_mis) begin
                            // Rejected without touching the bus.
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            address    <= {req_addr[ADDR_W-1:2], 2'b00};
                            byteenable <= lane_be;
                            writedata  <= lane_wd;
                            read       <= !lsu_is_store(req_op);
                            write      <= lsu_is_store(req_op);
                            wait_cnt   <= '0;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read         <= 1'b0;
                        write        <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= lsu_is_store(op_q) ? 32'h0 : lane_load;
                    end else if (wait_last) begin
                        read         <= 1'b0;
                        write        <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_lsu.sv
module tb_mips_lsu;
  import mips_cpu_definitions::*;

  localparam int ADDR_W      = 32;
  localparam int ALIGN_CHECK = 1;
  localparam int MAX_WAIT    = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_rt;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  mips_lsu #(
    .ADDR_W      (ADDR_W),
    .ALIGN_CHECK (ALIGN_CHECK),
    .MAX_WAIT    (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rt      (req_rt),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-level view of the little-endian access rules.
  task automatic ref_model(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rt, input logic [31:0] mem,
                           output logic [3:0] be, output logic [31:0] wd, output logic [31:0] res,
                           output bit mis, output bit st);
    int o, size, base;
    bit sgn;
    logic [7:0] mb[4];
    logic [7:0] rb[4];
    o = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      mb[i] = mem[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    be = 4'b0; wd = 32'h0; res = 32'h0; mis = 1'b0; sgn = 1'b0; size = 0;
    st = (op == SB) || (op == SH) || (op == SW);
    case (op)
      LB:  begin size = 1; sgn = 1'b1; end
      LBU: size = 1;
      LH:  begin size = 2; sgn = 1'b1; end
      LHU: size = 2;
      LW:  size = 4;
      SB:  size = 1;
      SH:  size = 2;
      SW:  size = 4;
      default: size = 0;
    endcase
    if (size != 0) begin
      mis  = (ALIGN_CHECK != 0) && ((o % size) != 0);
      base = o - (o % size);
      for (int k = 0; k < size; k++) begin
        be[base+k] = 1'b1;
        res[8*k +: 8] = mb[base+k];
      end
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
      if (sgn && res[8*size-1]) begin
        for (int k = size; k < 4; k++) res[8*k +: 8] = 8'hFF;
      end
    end else if (op == LWL) begin
      for (int k = 0; k <= o; k++) be[k] = 1'b1;
      for (int j = 0; j < 4; j++) res[8*j +: 8] = (j >= 3 - o) ? mb[o - (3 - j)] : rb[j];
    end else if (op == LWR) begin
      for (int k = o; k < 4; k++) be[k] = 1'b1;
      for (int j = 0; j < 4; j++) res[8*j +: 8] = (j <= 3 - o) ? mb[o + j] : rb[j];
    end
    if (mis || st) res = 32'h0;
  endtask

  // ---------------------------------------------------------------- driver
  // Issues one request and plays the Avalon slave: stalls the first nwait
  // strobe cycles, then returns mem. Samples everything on falling edges.
  task automatic run_txn(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rt, input logic [31:0] mem, input int nwait);
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_res, a0, wd0;
    logic [3:0]  be0;
    bit mis, st, tmo, saw_rd, saw_wr, both, stable, ready_low;
    int guard, cyc, strobes, resp_cyc, n_resp, exp_cyc, exp_strobes;

    ref_model(op, addr, wdata, rt, mem, e_be, e_wd, e_res, mis, st);
    tmo = !mis && (nwait >= MAX_WAIT);

    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("req_ready_idle", {31'b0, req_ready}, 32'd1);

    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rt = rt;
    exp_q.push_back(tmo ? 32'h0 : e_res);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = lsu_op_t'(4'($urandom_range(0, 9)));
    req_addr  = $urandom; req_wdata = $urandom; req_rt = $urandom;

    cyc = 1; strobes = 0; resp_cyc = 0; n_resp = 0;
    saw_rd = 0; saw_wr = 0; both = 0; stable = 1; ready_low = 1;
    a0 = 32'h0; be0 = 4'h0; wd0 = 32'h0;
    while (cyc <= 14) begin
      if (resp_cyc == 0 && req_ready) ready_low = 0;
      if (read && write) both = 1;
      if (read) saw_rd = 1;
      if (write) saw_wr = 1;
      if (read || write) begin
        if (strobes == 0) begin
          a0 = address; be0 = byteenable; wd0 = writedata;
        end else if (address != a0 || byteenable != be0 || writedata != wd0) begin
          stable = 0;
        end
        strobes++;
        waitrequest = (strobes <= nwait);
        readdata    = waitrequest ? $urandom : mem;
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
        readdata    = $urandom;
      end
      if (resp_valid) begin
        n_resp++;
        if (resp_cyc == 0) begin
          resp_cyc = cyc;
          check_val("resp_rdata", resp_rdata, exp_q.pop_front());
          check_val("resp_err", {31'b0, resp_err}, {31'b0, mis || tmo});
        end
      end
      if (resp_cyc != 0 && cyc == resp_cyc + 1) break;
      @(negedge clk);
      cyc++;
    end

    if (resp_cyc == 0) begin
      check_val("resp_seen", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    exp_cyc     = mis ? 1 : (tmo ? MAX_WAIT + 1 : nwait + 2);
    exp_strobes = mis ? 0 : (tmo ? MAX_WAIT : nwait + 1);
    check_val("resp_cycle", resp_cyc, exp_cyc);
    check_val("strobe_cycles", strobes, exp_strobes);
    check_val("resp_pulses", n_resp, 32'd1);
    check_val("read_seen", {31'b0, saw_rd}, {31'b0, !mis && !st});
    check_val("write_seen", {31'b0, saw_wr}, {31'b0, !mis && st});
    check_val("rd_wr_overlap", {31'b0, both}, 32'd0);
    check_val("ready_low_busy", {31'b0, ready_low}, 32'd1);
    check_val("ready_after_resp", {31'b0, req_ready}, 32'd1);
    if (strobes > 0) begin
      check_val("address", a0, {addr[31:2], 2'b00});
      check_val("byteenable", {28'b0, be0}, {28'b0, e_be});
      check_val("bus_stable", {31'b0, stable}, 32'd1);
      if (st) check_val("writedata", wd0, e_wd);
    end
  endtask

  // Reset while the bus is stalled: strobes drop on the next edge, no response.
  task automatic reset_mid_bus();
    int guard, n_resp;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_op = LW; req_addr = 32'h400; req_wdata = $urandom; req_rt = $urandom;
    @(negedge clk);
    req_valid   = 1'b0;
    waitrequest = 1'b1;
    check_val("rst_read_before", {31'b0, read}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_read_after", {31'b0, read}, 32'd0);
    check_val("rst_resp_after", {31'b0, resp_valid}, 32'd0);
    check_val("rst_ready_after", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;
    n_resp = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    check_val("rst_no_resp", n_resp, 32'd0);
    waitrequest = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = LB; req_addr = '0; req_wdata = '0; req_rt = '0;
    waitrequest = 1'b0; readdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'h0);
    check_val("rst_read", {31'b0, read}, 32'd0);
    check_val("rst_write", {31'b0, write}, 32'd0);
    check_val("rst_address", address, 32'h0);
    check_val("rst_byteenable", {28'b0, byteenable}, 32'h0);
    check_val("rst_writedata", writedata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(LW,  32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    run_txn(LB,  32'h103, 32'h0, 32'h0, 32'h80112233, 0);
    run_txn(LBU, 32'h103, 32'h0, 32'h0, 32'h80112233, 1);
    run_txn(SH,  32'h202, 32'h0000ABCD, 32'h0, 32'h0, 3);
    run_txn(LWL, 32'h301, 32'h0, 32'h11223344, 32'hAABBCCDD, 0);
    run_txn(LWR, 32'h302, 32'h0, 32'h11223344, 32'hAABBCCDD, 0);
    run_txn(LW,  32'h102, 32'h0, 32'h0, 32'h12345678, 0);
    run_txn(LW,  32'h500, 32'h0, 32'h0, 32'h12345678, 100);
    run_txn(SW,  32'h504, 32'hCAFEF00D, 32'h0, 32'h0, 0);
    reset_mid_bus();
    run_txn(LHU, 32'h606, 32'h0, 32'h0, 32'h8001FFFE, 2);

    for (int i = 0; i < 200; i++) begin
      run_txn(lsu_op_t'(4'($urandom_range(0, 9))), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
